mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns single word/halfword/byte load-store requests from
// the control unit into a sequence of byte accesses on a simple req/ack
// byte-memory port. Little-endian: byte 0 of a word sits at the base address.
//
// State table:
//   IDLE | waiting for mem_read/mem_write; decodes and checks the request
//   XFER | issuing bm_req for one byte at a time until the last ack or timeout
//   DONE | one-cycle done pulse (err alongside on a failed access)
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   mem_read, mem_write load / store request
//   MemCtr              access type (000 lw, 001 lbu, 010 lhu, 100 sw, 101 sb, 111 sh)
//   addr, wdata         byte address and store data
//   rdata               zero-extended load result, held until the next access
//   stall               combinational pipeline hold
//   done, err           one-cycle completion pulse and error flag
//   bm_*                byte-memory request/acknowledge port
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  MemCtr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        bm_req,
  output logic        bm_we,
  output logic [31:0] bm_addr,
  output logic [7:0]  bm_wdata,
  input  logic        bm_ack,
  input  logic [7:0]  bm_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bm_req_q, bm_req_d;
  logic [31:0] bm_addr_q, bm_addr_d;
  logic [7:0]  bm_wdata_q, bm_wdata_d;

  logic       code_ok;
  logic       misaligned;
  logic [1:0] last_idx;
  logic [1:0] idx_inc;

  // Request decode: direction must match MemCtr[2], and only the six
  // defined codes are accepted.
  always_comb begin
    code_ok = 1'b0;
    if (mem_read && !mem_write)
      code_ok = (MemCtr == 3'b000) || (MemCtr == 3'b001) || (MemCtr == 3'b010);
    else if (mem_write && !mem_read)
      code_ok = (MemCtr == 3'b100) || (MemCtr == 3'b101) || (MemCtr == 3'b111);

    case (MemCtr[1:0])
      2'b00:   last_idx = 2'd3;
      2'b01:   last_idx = 2'd0;
      default: last_idx = 2'd1;
    endcase

    case (MemCtr[1:0])
      2'b00:   misaligned = (addr[1:0] != 2'b00);
      2'b01:   misaligned = 1'b0;
      default: misaligned = addr[0];
    endcase
  end

  assign idx_inc = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bm_req_d   = bm_req_q;
    bm_addr_d  = bm_addr_q;
    bm_wdata_d = bm_wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          // Any new access discards the previous load result.
          rdata_d = 32'd0;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
          if (!code_ok || misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = XFER;
            last_d     = last_idx;
            we_d       = mem_write;
            wdata_d    = wdata;
            bm_req_d   = 1'b1;
            bm_addr_d  = addr;
            bm_wdata_d = wdata[7:0];
          end
        end
      end

      XFER: begin
        // An ack arriving in the final wait cycle still counts.
        if (bm_ack) begin
          cnt_d = 16'd0;
          if (!we_q)
            rdata_d[{idx_q, 3'b000} +: 8] = bm_rdata;
          if (idx_q == last_q) begin
            state_d  = DONE;
            done_d   = 1'b1;
            bm_req_d = 1'b0;
          end else begin
            idx_d      = idx_inc;
            bm_addr_d  = bm_addr_q + 32'd1;
            bm_wdata_d = wdata_q[{idx_inc, 3'b000} +: 8];
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'd0;
          bm_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = 16'd0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      last_q     <= 2'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      cnt_q      <= 16'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bm_req_q   <= 1'b0;
      bm_addr_q  <= 32'd0;
      bm_wdata_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bm_req_q   <= bm_req_d;
      bm_addr_q  <= bm_addr_d;
      bm_wdata_q <= bm_wdata_d;
    end
  end

  assign stall    = (state_q == XFER) || ((state_q == IDLE) && (mem_read || mem_write));
  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign bm_req   = bm_req_q;
  assign bm_we    = we_q;
  assign bm_addr  = bm_addr_q;
  assign bm_wdata = bm_wdata_q;

endmodule
